// File: rtl/traffic_pkg.sv
// Shared types and constants for the intersection controller: state codes,
// lamp encodings and default phase durations.
package traffic_pkg;

   typedef enum logic [2:0] {
      CLR_NS = 3'd0,
      NS_G   = 3'd1,
      NS_Y   = 3'd2,
      CLR_EW = 3'd3,
      EW_G   = 3'd4,
      EW_Y   = 3'd5,
      PED    = 3'd6
   } state_t;

   // Lamp encodings, {R,Y,G}
   localparam logic [2:0] RED    = 3'b100;
   localparam logic [2:0] YELLOW = 3'b010;
   localparam logic [2:0] GREEN  = 3'b001;

   localparam int DEF_RED_CLR   = 2;
   localparam int DEF_GREEN_MIN = 4;
   localparam int DEF_GREEN_MAX = 12;
   localparam int DEF_YELLOW    = 2;
   localparam int DEF_WALK      = 6;
   localparam int DEF_CNT_W     = 8;

endpackage

// File: rtl/phase_timer.sv
// Saturating phase counter: restarts at zero whenever the FSM changes state
// and holds at all-ones rather than wrapping during an indefinite green rest.
module phase_timer
   import traffic_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   output logic [CNT_W-1:0] cnt
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (cnt != '1) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/intersection_ctrl.sv
// Two-road intersection scheduler with demand-actuated greens, all-red
// clearance and a latched pedestrian walk phase.
//
// state  | meaning
// CLR_NS | all red, clearing before NS green
// NS_G   | NS green, EW red
// NS_Y   | NS yellow, EW red
// CLR_EW | all red, clearing before EW green
// EW_G   | EW green, NS red
// EW_Y   | EW yellow, NS red
// PED    | all red, walk on
module intersection_ctrl
   import traffic_pkg::*;
#(
   parameter int RED_CLR   = DEF_RED_CLR,
   parameter int GREEN_MIN = DEF_GREEN_MIN,
   parameter int GREEN_MAX = DEF_GREEN_MAX,
   parameter int YELLOW    = DEF_YELLOW,
   parameter int WALK      = DEF_WALK,
   parameter int CNT_W     = DEF_CNT_W
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       car_ns,
   input  logic       car_ew,
   input  logic       ped_req,
   output logic [2:0] light_ns,
   output logic [2:0] light_ew,
   output logic       walk,
   output logic       ped_ack,
   output logic [2:0] phase
);

   // Last cnt value of each timed phase (a phase of N cycles ends at N-1)
   localparam logic [CNT_W-1:0] CLR_LAST  = CNT_W'(RED_CLR - 1);
   localparam logic [CNT_W-1:0] GMIN_LAST = CNT_W'(GREEN_MIN - 1);
   localparam logic [CNT_W-1:0] GMAX_LAST = CNT_W'(GREEN_MAX - 1);
   localparam logic [CNT_W-1:0] Y_LAST    = CNT_W'(YELLOW - 1);
   localparam logic [CNT_W-1:0] WALK_LAST = CNT_W'(WALK - 1);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt;
   logic             state_chg;
   logic             enter_ped;
   logic             ped_pend;
   logic             next_ew;

   assign state_chg = (state_nxt != state);
   assign enter_ped = (state_nxt == PED) && (state != PED);
   assign phase     = state;

   phase_timer #(.CNT_W(CNT_W)) u_timer (
      .clk (clk),
      .rst (rst),
      .clr (state_chg),
      .cnt (cnt)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= CLR_NS;
      end else begin
         state <= state_nxt;
      end
   end

   // A request arriving in the first walk cycle overrides the clear so it is
   // served at the next yellow rather than being lost.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ped_pend <= 1'b0;
         next_ew  <= 1'b0;
         ped_ack  <= 1'b0;
      end else begin
         ped_ack <= enter_ped;
         if (enter_ped) begin
            next_ew <= (state == NS_Y);
         end
         if (ped_req) begin
            ped_pend <= 1'b1;
         end else if ((state == PED) && (cnt == '0)) begin
            ped_pend <= 1'b0;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      light_ns  = RED;
      light_ew  = RED;
      walk      = 1'b0;
      case (state)
         CLR_NS: begin
            if (cnt >= CLR_LAST) state_nxt = NS_G;
         end
         NS_G: begin
            light_ns = GREEN;
            if ((car_ew || ped_pend) &&
                ((cnt >= GMAX_LAST) || ((cnt >= GMIN_LAST) && !car_ns)))
               state_nxt = NS_Y;
         end
         NS_Y: begin
            light_ns = traffic_pkg::YELLOW;
            if (cnt >= Y_LAST) state_nxt = ped_pend ? PED : CLR_EW;
         end
         CLR_EW: begin
            if (cnt >= CLR_LAST) state_nxt = EW_G;
         end
         EW_G: begin
            light_ew = GREEN;
            if ((car_ns || ped_pend) &&
                ((cnt >= GMAX_LAST) || ((cnt >= GMIN_LAST) && !car_ew)))
               state_nxt = EW_Y;
         end
         EW_Y: begin
            light_ew = traffic_pkg::YELLOW;
            if (cnt >= Y_LAST) state_nxt = ped_pend ? PED : CLR_NS;
         end
         PED: begin
            walk = 1'b1;
            if (cnt >= WALK_LAST) state_nxt = next_ew ? CLR_EW : CLR_NS;
         end
         default: state_nxt = CLR_NS;
      endcase
   end

endmodule

// File: tb/tb_intersection_ctrl.sv
// Scoreboard bench for intersection_ctrl: stimulus queues the expected phase
// runs, a monitor measures each observed run and checks lamps every cycle.
module tb_intersection_ctrl;
   import traffic_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       car_ns = 1'b0;
   logic       car_ew = 1'b0;
   logic       ped_req = 1'b0;
   logic [2:0] light_ns, light_ew, phase;
   logic       walk, ped_ack;

   intersection_ctrl dut (
      .clk      (clk),
      .rst      (rst),
      .car_ns   (car_ns),
      .car_ew   (car_ew),
      .ped_req  (ped_req),
      .light_ns (light_ns),
      .light_ew (light_ew),
      .walk     (walk),
      .ped_ack  (ped_ack),
      .phase    (phase)
   );

   always #5 clk = ~clk;

   // exact=0 means the run must last at least len cycles (resting green or
   // a run cut short by reset)
   typedef struct packed {
      logic [2:0]  ph;
      logic [15:0] len;
      logic        exact;
   } run_t;

   run_t       exp_q[$];
   int         checks = 0;
   int         errors = 0;
   int         cur_c  = 0;
   logic [2:0] cur_ph = 3'd0;
   int         run_len = 0;
   bit         have_run = 1'b0;
   bit         in_rst = 1'b0;
   bit         prev_ns_g = 1'b0;
   bit         prev_ew_g = 1'b0;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic logic [6:0] exp_out(input logic [2:0] ph);
      case (ph)
         NS_G:    return {GREEN, RED, 1'b0};
         NS_Y:    return {YELLOW, RED, 1'b0};
         EW_G:    return {RED, GREEN, 1'b0};
         EW_Y:    return {RED, YELLOW, 1'b0};
         PED:     return {RED, RED, 1'b1};
         default: return {RED, RED, 1'b0};
      endcase
   endfunction

   task automatic finish_run();
      run_t e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL extra_run: phase %0d for %0d cycles, expected no further run", cur_ph, run_len);
         return;
      end
      e = exp_q.pop_front();
      if (cur_ph != e.ph) begin
         errors++;
         $display("FAIL run_phase: got phase %0d, expected phase %0d (t=%0t)", cur_ph, e.ph, $time);
      end
      checks++;
      if (e.exact ? (run_len != int'(e.len)) : (run_len < int'(e.len))) begin
         errors++;
         $display("FAIL run_len phase %0d: got %0d cycles, expected %s%0d (t=%0t)",
                  cur_ph, run_len, e.exact ? "" : ">=", e.len, $time);
      end
   endtask

   // Monitor: measure phase runs and check lamps each cycle; watcher checks
   // that reset forces all-red without waiting for a clock edge.
   initial begin
      fork
         forever begin
            logic [6:0] eo;
            @(negedge clk);
            if (rst) begin
               if (have_run && !in_rst) finish_run();
               in_rst   = 1'b1;
               have_run = 1'b1;
               cur_ph   = CLR_NS;
               run_len  = 1;
            end else begin
               in_rst = 1'b0;
               if (phase == cur_ph) begin
                  run_len++;
               end else begin
                  finish_run();
                  cur_ph  = phase;
                  run_len = 1;
               end
            end
            eo = exp_out(phase);
            chk("light_ns", int'(light_ns), int'(eo[6:4]));
            chk("light_ew", int'(light_ew), int'(eo[3:1]));
            chk("walk", int'(walk), int'(eo[0]));
            chk("ped_ack", int'(ped_ack), int'(!rst && phase == PED && run_len == 1));
            checks++;
            if ((light_ns != RED && light_ew != RED) ||
                (prev_ns_g && light_ew == GREEN) || (prev_ew_g && light_ns == GREEN)) begin
               errors++;
               $display("FAIL safety: ns=%b ew=%b prev_ns_g=%0d prev_ew_g=%0d", light_ns, light_ew,
                        prev_ns_g, prev_ew_g);
            end
            prev_ns_g = (light_ns == GREEN);
            prev_ew_g = (light_ew == GREEN);
         end
         forever begin
            @(posedge rst);
            #1;
            chk("rst_light_ns", int'(light_ns), int'(RED));
            chk("rst_light_ew", int'(light_ew), int'(RED));
            chk("rst_walk", int'(walk), 0);
            chk("rst_phase", int'(phase), int'(CLR_NS));
            chk("rst_ped_ack", int'(ped_ack), 0);
         end
      join_none
   end

   task automatic push(input logic [2:0] ph, input int len, input bit exact);
      run_t e;
      e.ph    = ph;
      e.len   = 16'(len);
      e.exact = exact;
      exp_q.push_back(e);
   endtask

   // Cycle 1 is the cycle in which rst falls; inputs set in cycle c are
   // sampled at the edge that ends cycle c.
   task automatic goto(input int c);
      repeat (c - cur_c) @(negedge clk);
      cur_c = c;
   endtask

   task automatic do_reset(input logic ns, input logic ew);
      #2 rst = 1'b1;
      car_ns  = ns;
      car_ew  = ew;
      ped_req = 1'b0;
      repeat (2) @(negedge clk);
      #2 rst = 1'b0;
      cur_c = 1;
   endtask

   initial begin
      // No demand: NS rests in green, EW stays red
      push(CLR_NS, 2, 1); push(NS_G, 50, 0);
      #1 rst = 1'b1;
      repeat (2) @(negedge clk);
      #2 rst = 1'b0;
      cur_c = 1;
      goto(20); car_ns = 1'b1;
      goto(60);

      // Both roads busy: greens run to GREEN_MAX
      push(CLR_NS, 2, 1); push(NS_G, 12, 1); push(NS_Y, 2, 1); push(CLR_EW, 2, 1);
      push(EW_G, 12, 1); push(EW_Y, 2, 1); push(CLR_NS, 2, 1); push(NS_G, 1, 0);
      do_reset(1'b1, 1'b1);
      goto(40);

      // Only EW waiting: NS green cut at GREEN_MIN, EW then rests
      push(CLR_NS, 2, 1); push(NS_G, 4, 1); push(NS_Y, 2, 1); push(CLR_EW, 2, 1);
      push(EW_G, 10, 0);
      do_reset(1'b0, 1'b1);
      goto(30);

      // Pedestrian request at NS green cnt=1 inserts a walk phase
      push(CLR_NS, 2, 1); push(NS_G, 4, 1); push(NS_Y, 2, 1); push(PED, 6, 1);
      push(CLR_EW, 2, 1); push(EW_G, 5, 0);
      do_reset(1'b0, 1'b0);
      goto(4); ped_req = 1'b1;
      goto(5); ped_req = 1'b0;
      goto(25);

      // Request repeated in the first walk cycle is served again after EW yellow
      push(CLR_NS, 2, 1); push(NS_G, 4, 1); push(NS_Y, 2, 1); push(PED, 6, 1);
      push(CLR_EW, 2, 1); push(EW_G, 4, 1); push(EW_Y, 2, 1); push(PED, 6, 1);
      push(CLR_NS, 2, 1); push(NS_G, 3, 0);
      do_reset(1'b0, 1'b0);
      goto(4); ped_req = 1'b1;
      goto(5); ped_req = 1'b0;
      goto(9); ped_req = 1'b1;
      goto(10); ped_req = 1'b0;
      goto(36);

      // Reset in NS yellow at cnt=1 aborts straight to clearance
      push(CLR_NS, 2, 1); push(NS_G, 4, 1); push(NS_Y, 2, 1);
      do_reset(1'b0, 1'b1);
      goto(8);
      push(CLR_NS, 2, 1); push(NS_G, 5, 0);
      do_reset(1'b0, 1'b0);
      goto(12);

      #2 rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL missing_runs: %0d expected runs never observed, expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
